frame_sync_controller: RTL and testbench

Frame synchronisation state machine placed directly after the preamble detector in the receive chain. It consumes the per-bit detect flag, confirms a periodic preamble over several frames before declaring lock, and keeps a flywheel bit counter running through isolated missed preambles. It emits frame-start pulses, a payload-bit qualifier and the bit index, and it clears the detector's history when lock is lost.

---
 rtl/frame_sync_controller.sv | 176 +++++++++++++++++
 tb/tb_frame_sync_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_controller.sv
// frame_sync_controller
//   Frame synchroniser that follows the preamble detector. It confirms a
//   periodic preamble over CONFIRM_CNT frames before declaring lock, keeps a
//   flywheel bit counter through isolated missed preambles, and drops lock
//   after LOSS_CNT consecutive misses.
//
// Parameters
//   FRAME_LEN    frame period in bits, preamble included (>= 4)
//   CONFIRM_CNT  consecutive on-time detects needed to lock (>= 1)
//   LOSS_CNT     consecutive missed expected detects that drop lock (>= 1)
//
// Ports
//   CLK             in   rising-edge clock
//   RESET_N         in   asynchronous active-low reset
//   DETECT_IN       in   preamble detect flag
//   DETECT_IN_VALID in   one-cycle strobe per received bit
//   SYNC_LOCK       out  high while locked
//   FRAME_START     out  pulse on each frame boundary while locked
//   PAYLOAD_VALID   out  pulse per non-boundary bit while locked
//   BIT_IDX         out  bit position within the frame (0 = boundary)
//   FINDER_RESET    out  one-cycle clear pulse to the preamble detector
//   LOSS_COUNT      out  saturating count of lock losses
//                        (only when FRAME_SYNC_STATS_EN is defined)
//
// All outputs are registered and react one clock after the causing strobe.
module frame_sync_controller #(
  parameter int FRAME_LEN   = 64,
  parameter int CONFIRM_CNT = 3,
  parameter int LOSS_CNT    = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         DETECT_IN,
  input  logic                         DETECT_IN_VALID,
  output logic                         SYNC_LOCK,
  output logic                         FRAME_START,
  output logic                         PAYLOAD_VALID,
  output logic [$clog2(FRAME_LEN)-1:0] BIT_IDX,
  output logic                         FINDER_RESET
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0]                  LOSS_COUNT
`endif
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(CONFIRM_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [HW-1:0] HITS_ONE = HW'(1);
  localparam logic [HW-1:0] CONF_V   = HW'(CONFIRM_CNT);
  localparam logic [MW-1:0] MISS_ONE = MW'(1);
  localparam logic [MW-1:0] LOSS_V   = MW'(LOSS_CNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hits_q, hits_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic            lock_q, fs_q, pv_q, fr_q;
  logic            expected;

  // Expected strobe: the one that wraps the bit counter back to the boundary.
  assign expected = (cnt_q == CNT_LAST);
  assign cnt_d    = expected ? '0 : cnt_q + CNT_ONE;
  // Increments are only taken while below the limit, so they never overflow.
  assign hits_d   = hits_q + HITS_ONE;
  assign miss_d   = miss_q + MISS_ONE;

`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] loss_cnt_q;
  assign LOSS_COUNT = loss_cnt_q;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      hits_q  <= '0;
      miss_q  <= '0;
      lock_q  <= 1'b0;
      fs_q    <= 1'b0;
      pv_q    <= 1'b0;
      fr_q    <= 1'b0;
`ifdef FRAME_SYNC_STATS_EN
      loss_cnt_q <= '0;
`endif
    end else begin
      // Pulse outputs default low; only a strobe can raise them.
      fs_q <= 1'b0;
      pv_q <= 1'b0;
      fr_q <= 1'b0;
      if (DETECT_IN_VALID) begin
        case (state_q)
          SEARCH: begin
            cnt_q <= '0;
            if (DETECT_IN) begin
              hits_q <= HITS_ONE;
              if (CONFIRM_CNT == 1) begin
                state_q <= LOCK;
                lock_q  <= 1'b1;
                fs_q    <= 1'b1;
                miss_q  <= '0;
              end else begin
                state_q <= VERIFY;
              end
            end
          end
          VERIFY: begin
            cnt_q <= cnt_d;
            // Off-position detects are ignored while verifying.
            if (expected) begin
              if (DETECT_IN) begin
                hits_q <= hits_d;
                if (hits_d == CONF_V) begin
                  state_q <= LOCK;
                  lock_q  <= 1'b1;
                  fs_q    <= 1'b1;
                  miss_q  <= '0;
                end
              end else begin
                state_q <= SEARCH;
                hits_q  <= '0;
                fr_q    <= 1'b1;
              end
            end
          end
          LOCK: begin
            // The counter free-runs; detects never re-align it here.
            cnt_q <= cnt_d;
            if (!expected) begin
              pv_q <= 1'b1;
            end else if (DETECT_IN) begin
              miss_q <= '0;
              fs_q   <= 1'b1;
            end else if (miss_d == LOSS_V) begin
              // Lock loss suppresses the flywheel frame-start pulse.
              state_q <= SEARCH;
              lock_q  <= 1'b0;
              fr_q    <= 1'b1;
              miss_q  <= '0;
              hits_q  <= '0;
`ifdef FRAME_SYNC_STATS_EN
              if (loss_cnt_q != 16'hFFFF) begin
                loss_cnt_q <= loss_cnt_q + 16'd1;
              end
`endif
            end else begin
              miss_q <= miss_d;
              fs_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= SEARCH;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SYNC_LOCK     = lock_q;
  assign FRAME_START   = fs_q;
  assign PAYLOAD_VALID = pv_q;
  assign FINDER_RESET  = fr_q;
  assign BIT_IDX       = cnt_q;

endmodule

// File: tb/tb_frame_sync_controller.sv
// Directed bench for frame_sync_controller with FRAME_LEN=16,
// CONFIRM_CNT=3, LOSS_CNT=2. Inputs change on the falling edge and outputs
// are sampled on the following falling edge.
module tb_frame_sync_controller;

  logic       clk;
  logic       rst_n;
  logic       det;
  logic       det_vld;
  logic       sync_lock;
  logic       frame_start;
  logic       payload_valid;
  logic [3:0] bit_idx;
  logic       finder_reset;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] loss_count;
`endif

  int tests;
  int errors;
  int g;
  int pv_acc, fs_acc, fr_acc, lock_acc;

  frame_sync_controller #(
    .FRAME_LEN  (16),
    .CONFIRM_CNT(3),
    .LOSS_CNT   (2)
  ) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .DETECT_IN      (det),
    .DETECT_IN_VALID(det_vld),
    .SYNC_LOCK      (sync_lock),
    .FRAME_START    (frame_start),
    .PAYLOAD_VALID  (payload_valid),
    .BIT_IDX        (bit_idx),
    .FINDER_RESET   (finder_reset)
`ifdef FRAME_SYNC_STATS_EN
    ,
    .LOSS_COUNT     (loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_acc();
    pv_acc = 0; fs_acc = 0; fr_acc = 0; lock_acc = 0;
  endtask

  // One clock with the given inputs; outputs for it are visible on return.
  task automatic step(input logic d, input logic v);
    det_vld = v;
    det     = d;
    @(negedge clk);
    det_vld = 1'b0;
    det     = 1'b0;
    pv_acc   += int'(payload_valid);
    fs_acc   += int'(frame_start);
    fr_acc   += int'(finder_reset);
    lock_acc += int'(sync_lock);
  endtask

  task automatic idle();
    repeat (g) step(1'b0, 1'b0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1);
      idle();
    end
  endtask

  initial begin
    tests = 0; errors = 0; g = 0;
    clear_acc();
    rst_n = 1'b0; det = 1'b0; det_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lock", sync_lock, 0);
    check("rst_fs", frame_start, 0);
    check("rst_pv", payload_valid, 0);
    check("rst_fr", finder_reset, 0);
    check("rst_idx", bit_idx, 0);
`ifdef FRAME_SYNC_STATS_EN
    check("rst_loss_count", loss_count, 0);
`endif
    rst_n = 1'b1;

    // Acquisition
    strobes(4);
    check("search_idx", bit_idx, 0);
    step(1'b1, 1'b1);
    check("acq1_lock", sync_lock, 0);
    check("acq1_idx", bit_idx, 0);
    step(1'b0, 1'b1);
    check("verify_idx1", bit_idx, 1);
    strobes(7);
    step(1'b1, 1'b1);
    check("verify_offpos_idx", bit_idx, 9);
    strobes(5);
    step(1'b0, 1'b1);
    check("verify_idx15", bit_idx, 15);
    step(1'b1, 1'b1);
    check("acq2_lock", sync_lock, 0);
    check("acq2_fs", frame_start, 0);
    check("acq2_idx", bit_idx, 0);
    strobes(15);
    step(1'b1, 1'b1);
    check("acq3_lock", sync_lock, 1);
    check("acq3_fs", frame_start, 1);
    check("acq3_idx", bit_idx, 0);
    check("acq3_pv", payload_valid, 0);
    clear_acc();
    strobes(15);
    check("frame_pv_count", pv_acc, 15);
    check("frame_fs_count", fs_acc, 0);
    check("frame_idx15", bit_idx, 15);

    // Flywheel through one miss
    step(1'b0, 1'b1);
    check("fly_fs", frame_start, 1);
    check("fly_lock", sync_lock, 1);
    check("fly_fr", finder_reset, 0);
    check("fly_idx", bit_idx, 0);
    strobes(15);
    step(1'b1, 1'b1);
    check("fly_recover_fs", frame_start, 1);
    strobes(15);
    step(1'b0, 1'b1);
    check("miss_cleared_lock", sync_lock, 1);
    check("miss_cleared_fs", frame_start, 1);

    // Lock loss on second consecutive miss
    strobes(15);
    step(1'b0, 1'b1);
    check("loss_lock", sync_lock, 0);
    check("loss_fr", finder_reset, 1);
    check("loss_fs", frame_start, 0);
    check("loss_idx", bit_idx, 0);
`ifdef FRAME_SYNC_STATS_EN
    check("loss_count", loss_count, 1);
`endif
    step(1'b0, 1'b0);
    check("loss_fr_single", finder_reset, 0);
    step(1'b0, 1'b1);
    check("search_hold_idx", bit_idx, 0);

    // Verify failure
    clear_acc();
    step(1'b1, 1'b1);
    strobes(15);
    step(1'b1, 1'b1);
    strobes(15);
    step(1'b0, 1'b1);
    check("vfail_fr", finder_reset, 1);
    check("vfail_lock", sync_lock, 0);
    check("vfail_idx", bit_idx, 0);
    check("vfail_fr_count", fr_acc, 1);
    check("vfail_lock_never", lock_acc, 0);
    step(1'b0, 1'b0);
    check("vfail_fr_single", finder_reset, 0);

    // Gapped strobes: one strobe every third cycle
    step(1'b1, 1'b1);
    g = 2;
    idle();
    step(1'b0, 1'b1);
    check("gap_restart_idx", bit_idx, 1);
    idle();
    strobes(14);
    step(1'b1, 1'b1);
    idle();
    strobes(15);
    step(1'b1, 1'b1);
    check("gap_lock", sync_lock, 1);
    check("gap_fs", frame_start, 1);
    idle();
    check("gap_idle_fs", frame_start, 0);
    check("gap_idle_idx", bit_idx, 0);
    clear_acc();
    strobes(6);
    step(1'b1, 1'b1);
    check("spurious_idx", bit_idx, 7);
    check("spurious_pv", payload_valid, 1);
    check("spurious_fs", frame_start, 0);
    idle();
    strobes(8);
    check("spurious_idx15", bit_idx, 15);
    check("spurious_fs_count", fs_acc, 0);
    check("spurious_pv_count", pv_acc, 15);
    step(1'b1, 1'b1);
    check("spurious_period_fs", frame_start, 1);
    check("spurious_period_idx", bit_idx, 0);
    idle();

    // Asynchronous reset mid-frame
    strobes(9);
    check("pre_rst_idx", bit_idx, 9);
    check("pre_rst_lock", sync_lock, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lock", sync_lock, 0);
    check("arst_idx", bit_idx, 0);
    check("arst_fs", frame_start, 0);
    check("arst_pv", payload_valid, 0);
    check("arst_fr", finder_reset, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    g = 0;
    step(1'b1, 1'b1);
    check("reacq1_lock", sync_lock, 0);
    check("reacq1_idx", bit_idx, 0);
    strobes(15);
    step(1'b1, 1'b1);
    check("reacq2_lock", sync_lock, 0);
    strobes(15);
    step(1'b1, 1'b1);
    check("reacq3_lock", sync_lock, 1);
    check("reacq3_fs", frame_start, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
